// File: rtl/signed_left_shift_expander_pkg.sv
// Shared DSP helpers: signed full-scale limits and shift clamping.
package usrp_dsp_pkg;

   // Largest positive value representable in a w-bit two's complement word.
   function automatic longint max_s(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Most negative value representable in a w-bit two's complement word.
   function automatic longint min_s(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   // Requested shift limited to the largest shift the datapath honours.
   function automatic int unsigned clamp_shift(input int unsigned req,
                                               input int unsigned max_shift);
      return (req > max_shift) ? max_shift : req;
   endfunction

endpackage

// File: rtl/signed_left_shift_expander_if.sv
// Sample, control and statistics bundle for the left-shift expander.
interface signed_left_shift_expander_if #(
   parameter int IN_LEN  = 16,
   parameter int OUT_LEN = 24,
   parameter int SHIFT_W = 5,
   parameter int CNT_W   = 16
);
   logic                      enable;
   logic [SHIFT_W-1:0]        shift_amt;
   logic signed [IN_LEN-1:0]  in_data;
   logic                      in_strobe;
   logic                      clr_stats;
   logic signed [OUT_LEN-1:0] out_data;
   logic                      out_strobe;
   logic                      sat_hi;
   logic                      sat_lo;
   logic                      sat_sticky;
   logic [CNT_W-1:0]          sat_count;

   modport master (
      output enable, shift_amt, in_data, in_strobe, clr_stats,
      input  out_data, out_strobe, sat_hi, sat_lo, sat_sticky, sat_count
   );

   modport slave (
      input  enable, shift_amt, in_data, in_strobe, clr_stats,
      output out_data, out_strobe, sat_hi, sat_lo, sat_sticky, sat_count
   );
endinterface

// File: rtl/signed_left_shift_expander_saturate.sv
// Combinational signed clamp of a wide value into an OUT_W-bit word.
module signed_saturate
   import usrp_dsp_pkg::*;
#(
   parameter int IN_W  = 28,
   parameter int OUT_W = 24
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    hi,
   output logic                    lo
);
   logic signed [63:0] v;

   assign v = longint'(din);

   // Compare in 64 bits so either width ordering works; exact limits do not clip.
   always_comb begin
      hi   = (v > max_s(OUT_W));
      lo   = (v < min_s(OUT_W));
      dout = OUT_W'(v);
      if (hi) begin
         dout = OUT_W'(max_s(OUT_W));
      end else if (lo) begin
         dout = OUT_W'(min_s(OUT_W));
      end
   end
endmodule

// File: rtl/signed_left_shift_expander.sv
// Two-stage signed left-shift widener with output saturation and clip statistics.
module signed_left_shift_expander
   import usrp_dsp_pkg::*;
#(
   parameter int IN_LEN    = 16,
   parameter int OUT_LEN   = 24,
   parameter int SHIFT_W   = 5,
   parameter int MAX_SHIFT = 12,
   parameter int CNT_W     = 16
) (
   input  logic                         clock,
   input  logic                         reset_n,
   signed_left_shift_expander_if.slave  bus
);
   // Wide enough that the largest honoured shift never drops a bit.
   localparam int WIDE_W = IN_LEN + MAX_SHIFT;

   logic signed [IN_LEN-1:0]  data_q,       data_d;
   logic [SHIFT_W-1:0]        shift_q,      shift_d;
   logic                      valid1_q,     valid1_d;
   logic signed [OUT_LEN-1:0] out_data_q,   out_data_d;
   logic                      out_strobe_q, out_strobe_d;
   logic                      sat_hi_q,     sat_hi_d;
   logic                      sat_lo_q,     sat_lo_d;
   logic                      sticky_q,     sticky_d;
   logic [CNT_W-1:0]          count_q,      count_d;

   logic signed [WIDE_W-1:0]  wide;
   logic signed [OUT_LEN-1:0] sat_val;
   logic                      sat_hi_w;
   logic                      sat_lo_w;

   assign wide = WIDE_W'(data_q) <<< shift_q;

   signed_saturate #(
      .IN_W  (WIDE_W),
      .OUT_W (OUT_LEN)
   ) u_sat (
      .din  (wide),
      .dout (sat_val),
      .hi   (sat_hi_w),
      .lo   (sat_lo_w)
   );

   // Stage 1: capture sample and its clamped shift; data holds between strobes.
   always_comb begin
      data_d   = data_q;
      shift_d  = shift_q;
      valid1_d = 1'b0;
      if (bus.enable && bus.in_strobe) begin
         data_d   = bus.in_data;
         shift_d  = SHIFT_W'(clamp_shift(32'(bus.shift_amt), int'(MAX_SHIFT)));
         valid1_d = 1'b1;
      end
   end

   // Stage 2: saturated result; enable low discards the sample in flight.
   always_comb begin
      out_data_d   = out_data_q;
      out_strobe_d = 1'b0;
      sat_hi_d     = 1'b0;
      sat_lo_d     = 1'b0;
      if (bus.enable && valid1_q) begin
         out_data_d   = sat_val;
         out_strobe_d = 1'b1;
         sat_hi_d     = sat_hi_w;
         sat_lo_d     = sat_lo_w;
      end
   end

   // Statistics update on the same edge the clipped sample is presented; clear wins.
   always_comb begin
      sticky_d = sticky_q;
      count_d  = count_q;
      if (bus.enable && bus.clr_stats) begin
         sticky_d = 1'b0;
         count_d  = '0;
      end else if (sat_hi_d || sat_lo_d) begin
         sticky_d = 1'b1;
         if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // All pipeline and statistics state, cleared asynchronously.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q       <= '0;
         shift_q      <= '0;
         valid1_q     <= 1'b0;
         out_data_q   <= '0;
         out_strobe_q <= 1'b0;
         sat_hi_q     <= 1'b0;
         sat_lo_q     <= 1'b0;
         sticky_q     <= 1'b0;
         count_q      <= '0;
      end else begin
         data_q       <= data_d;
         shift_q      <= shift_d;
         valid1_q     <= valid1_d;
         out_data_q   <= out_data_d;
         out_strobe_q <= out_strobe_d;
         sat_hi_q     <= sat_hi_d;
         sat_lo_q     <= sat_lo_d;
         sticky_q     <= sticky_d;
         count_q      <= count_d;
      end
   end

   assign bus.out_data   = out_data_q;
   assign bus.out_strobe = out_strobe_q;
   assign bus.sat_hi     = sat_hi_q;
   assign bus.sat_lo     = sat_lo_q;
   assign bus.sat_sticky = sticky_q;
   assign bus.sat_count  = count_q;
endmodule

// File: tb/tb_signed_left_shift_expander.sv
// Bench for signed_left_shift_expander: vector table, scoreboard queue, hand sequences.
module tb_signed_left_shift_expander;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   signed_left_shift_expander_if #(.IN_LEN(16), .OUT_LEN(24), .SHIFT_W(5), .CNT_W(16)) ifc ();
   signed_left_shift_expander_if #(.IN_LEN(16), .OUT_LEN(24), .SHIFT_W(5), .CNT_W(3))  ifc3 ();

   // Narrow-counter twin shares all stimulus so counter saturation is reachable quickly.
   assign ifc3.enable    = ifc.enable;
   assign ifc3.shift_amt = ifc.shift_amt;
   assign ifc3.in_data   = ifc.in_data;
   assign ifc3.in_strobe = ifc.in_strobe;
   assign ifc3.clr_stats = ifc.clr_stats;

   signed_left_shift_expander #(.IN_LEN(16), .OUT_LEN(24), .SHIFT_W(5), .MAX_SHIFT(12), .CNT_W(16)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (ifc)
   );

   signed_left_shift_expander #(.IN_LEN(16), .OUT_LEN(24), .SHIFT_W(5), .MAX_SHIFT(12), .CNT_W(3)) dut3 (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (ifc3)
   );

   typedef struct {
      logic signed [15:0] din;
      logic [4:0]         sh;
      logic signed [23:0] dout;
      logic               hi;
      logic               lo;
   } vec_t;

   typedef struct {
      logic signed [23:0] dout;
      logic               hi;
      logic               lo;
      int                 due;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[16];

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;
   logic signed [23:0] last_out = '0;
   logic exp_sticky = 1'b0;
   int   exp_cnt  = 0;
   int   exp_cnt3 = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc_n);
      end
   endtask

   function automatic exp_t model(input logic signed [15:0] d, input logic [4:0] sh);
      exp_t e;
      int s = (sh > 5'd12) ? 12 : int'(sh);
      longint v = longint'(d) <<< s;
      e.hi  = (v > 64'sd8388607);
      e.lo  = (v < -64'sd8388608);
      e.dout = e.hi ? 24'sd8388607 : e.lo ? -24'sd8388608 : 24'(v);
      e.due = 0;
      return e;
   endfunction

   // Apply inputs for the next edge and record what the DUT owes two edges later.
   task automatic drive(input bit en, input bit stb, input logic signed [15:0] d,
                        input logic [4:0] sh, input bit clr,
                        input logic signed [23:0] eo, input bit ehi, input bit elo);
      ifc.enable    = en;
      ifc.in_strobe = stb;
      ifc.in_data   = d;
      ifc.shift_amt = sh;
      ifc.clr_stats = clr;
      if (!en) begin
         for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].due == cyc_n + 1) sbq.delete(i);
      end
      if (en && stb) sbq.push_back('{dout: eo, hi: ehi, lo: elo, due: cyc_n + 2});
   endtask

   task automatic drive_model(input bit stb, input logic signed [15:0] d, input logic [4:0] sh);
      exp_t e = model(d, sh);
      drive(1'b1, stb, d, sh, 1'b0, e.dout, e.hi, e.lo);
   endtask

   task automatic idle(input bit clr);
      drive(1'b1, 1'b0, '0, '0, clr, '0, 1'b0, 1'b0);
   endtask

   // One clock: compare outputs against the scoreboard and the statistics model.
   task automatic step();
      bit en_e  = ifc.enable;
      bit clr_e = ifc.clr_stats;
      bit clip  = 1'b0;
      exp_t e;
      @(posedge clk);
      #1;
      cyc_n++;
      if (sbq.size() > 0 && sbq[0].due == cyc_n) begin
         e = sbq.pop_front();
         chk("out_strobe", ifc.out_strobe, 1);
         chk("out_data", ifc.out_data, e.dout);
         chk("sat_hi", ifc.sat_hi, e.hi);
         chk("sat_lo", ifc.sat_lo, e.lo);
         chk("out_data_twin", ifc3.out_data, e.dout);
         last_out = e.dout;
         clip = e.hi | e.lo;
      end else begin
         chk("out_strobe_idle", ifc.out_strobe, 0);
         chk("sat_flags_idle", {ifc.sat_hi, ifc.sat_lo}, 0);
         chk("out_data_hold", ifc.out_data, last_out);
      end
      if (en_e && clr_e) begin
         exp_sticky = 1'b0;
         exp_cnt    = 0;
         exp_cnt3   = 0;
      end else if (clip) begin
         exp_sticky = 1'b1;
         if (exp_cnt < 65535) exp_cnt++;
         if (exp_cnt3 < 7) exp_cnt3++;
      end
      chk("sat_sticky", ifc.sat_sticky, exp_sticky);
      chk("sat_count", ifc.sat_count, exp_cnt);
      chk("sat_count_w3", ifc3.sat_count, exp_cnt3);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_out_data"}, ifc.out_data, 0);
      chk({tag, "_out_strobe"}, ifc.out_strobe, 0);
      chk({tag, "_sat_flags"}, {ifc.sat_hi, ifc.sat_lo}, 0);
      chk({tag, "_sticky"}, ifc.sat_sticky, 0);
      chk({tag, "_count"}, ifc.sat_count, 0);
      chk({tag, "_count_w3"}, ifc3.sat_count, 0);
   endtask

   initial begin
      tbl[0]  = '{din: -16'sd3,     sh: 5'd4,  dout: -24'sd48,      hi: 1'b0, lo: 1'b0};
      tbl[1]  = '{din: 16'sh7FFF,   sh: 5'd12, dout: 24'sd8388607,  hi: 1'b1, lo: 1'b0};
      tbl[2]  = '{din: -16'sd32768, sh: 5'd9,  dout: -24'sd8388608, hi: 1'b0, lo: 1'b1};
      tbl[3]  = '{din: -16'sd32768, sh: 5'd8,  dout: -24'sd8388608, hi: 1'b0, lo: 1'b0};
      tbl[4]  = '{din: 16'sd1,      sh: 5'd31, dout: 24'sd4096,     hi: 1'b0, lo: 1'b0};
      tbl[5]  = '{din: 16'sd7,      sh: 5'd0,  dout: 24'sd7,        hi: 1'b0, lo: 1'b0};
      tbl[6]  = '{din: 16'sd7,      sh: 5'd5,  dout: 24'sd224,      hi: 1'b0, lo: 1'b0};
      tbl[7]  = '{din: 16'sd7,      sh: 5'd0,  dout: 24'sd7,        hi: 1'b0, lo: 1'b0};
      tbl[8]  = '{din: 16'sd7,      sh: 5'd5,  dout: 24'sd224,      hi: 1'b0, lo: 1'b0};
      tbl[9]  = '{din: 16'sh7FFF,   sh: 5'd0,  dout: 24'sd32767,    hi: 1'b0, lo: 1'b0};
      tbl[10] = '{din: -16'sd1,     sh: 5'd12, dout: -24'sd4096,    hi: 1'b0, lo: 1'b0};
      tbl[11] = '{din: 16'sh7FFF,   sh: 5'd8,  dout: 24'sd8388352,  hi: 1'b0, lo: 1'b0};
      tbl[12] = '{din: 16'sh4000,   sh: 5'd9,  dout: 24'sd8388607,  hi: 1'b1, lo: 1'b0};
      tbl[13] = '{din: -16'sd32768, sh: 5'd0,  dout: -24'sd32768,   hi: 1'b0, lo: 1'b0};
      tbl[14] = '{din: 16'sh1234,   sh: 5'd13, dout: 24'sd8388607,  hi: 1'b1, lo: 1'b0};
      tbl[15] = '{din: 16'sd100,    sh: 5'd12, dout: 24'sd409600,   hi: 1'b0, lo: 1'b0};

      ifc.enable = 1'b1; ifc.in_strobe = 1'b0; ifc.in_data = '0;
      ifc.shift_amt = '0; ifc.clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Single sample: latency and one-cycle pulse.
      drive(1'b1, 1'b1, tbl[0].din, tbl[0].sh, 1'b0, tbl[0].dout, tbl[0].hi, tbl[0].lo);
      step();
      idle(1'b0);
      repeat (3) step();

      // Remaining table entries back-to-back.
      for (int i = 1; i < 16; i++) begin
         drive(1'b1, 1'b1, tbl[i].din, tbl[i].sh, 1'b0, tbl[i].dout, tbl[i].hi, tbl[i].lo);
         step();
      end
      idle(1'b0);
      repeat (3) step();
      chk("table_clip_count", ifc.sat_count, 4);
      chk("table_sticky", ifc.sat_sticky, 1);

      // 100 consecutive clips after a clear; narrow counter must pin at 7.
      idle(1'b1);
      step();
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 1'b1, 16'sh7FFF, 5'd12, 1'b0, 24'sd8388607, 1'b1, 1'b0);
         step();
      end
      idle(1'b0);
      repeat (3) step();
      chk("burst_count", ifc.sat_count, 100);
      chk("burst_count_w3_held", ifc3.sat_count, 7);

      // Clear coincident with a clipped output drops that event.
      drive(1'b1, 1'b1, -16'sd32768, 5'd12, 1'b0, -24'sd8388608, 1'b0, 1'b1);
      step();
      idle(1'b1);
      step();
      chk("clr_wins_count", ifc.sat_count, 0);
      chk("clr_wins_sticky", ifc.sat_sticky, 0);
      chk("clr_wins_strobe", ifc.out_strobe, 1);
      idle(1'b0);
      step();
      drive(1'b1, 1'b1, 16'sh7FFF, 5'd10, 1'b0, 24'sd8388607, 1'b1, 1'b0);
      step();
      idle(1'b0);
      repeat (2) step();
      chk("clip_after_clear", ifc.sat_count, 1);

      // Random back-to-back samples with occasional gaps.
      for (int i = 0; i < 24; i++) begin
         drive_model(($urandom_range(0, 3) != 0), 16'($urandom), 5'($urandom_range(0, 31)));
         step();
      end
      idle(1'b0);
      repeat (2) step();

      // Enable drop for one cycle discards the two samples in flight.
      for (int i = 0; i < 5; i++) begin
         drive_model(1'b1, 16'(i * 911 - 1500), 5'(i + 3));
         step();
      end
      drive(1'b0, 1'b1, 16'sd555, 5'd2, 1'b0, '0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 3; i++) begin
         drive_model(1'b1, 16'(-i * 77 + 33), 5'(i));
         step();
      end
      idle(1'b0);
      repeat (3) step();

      // Asynchronous reset between edges with samples in flight.
      drive(1'b1, 1'b1, 16'sh7FFF, 5'd12, 1'b0, 24'sd8388607, 1'b1, 1'b0);
      step();
      drive(1'b1, 1'b1, 16'sd9, 5'd1, 1'b0, 24'sd18, 1'b0, 1'b0);
      step();
      chk("pre_reset_sticky", ifc.sat_sticky, 1);
      ifc.in_strobe = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      sbq.delete();
      last_out   = '0;
      exp_sticky = 1'b0;
      exp_cnt    = 0;
      exp_cnt3   = 0;
      #2;
      rst_n = 1'b1;
      idle(1'b0);
      repeat (3) step();

      chk("scoreboard_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/signed_left_shift_expander.md
Name: signed_left_shift_expander

Overview:
- Widening counterpart of the saturating narrowing stage on the PID datapath.
- Takes strobed signed samples at controller rate and left-shifts each by a runtime gain exponent into a wider output word.
- Saturates the result at the output full scale and keeps saturation statistics for host readback.
- Sits between the PID accumulator output and the DAC/TX scaling path.

Parameters:
IN_LEN, 16, input sample width (signed)
OUT_LEN, 24, output sample width (signed); OUT_LEN >= IN_LEN required
SHIFT_W, 5, width of shift_amt port
MAX_SHIFT, 12, largest honoured shift; larger requests are clamped to this value
CNT_W, 16, width of saturation event counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  synchronous run enable; low flushes the pipeline
shift_amt  input  SHIFT_W  unsigned left-shift amount, sampled with in_strobe
in_data  input  IN_LEN  signed input sample
in_strobe  input  1  one-cycle qualifier for in_data and shift_amt
out_data  output  OUT_LEN  signed scaled, saturated sample
out_strobe  output  1  one-cycle qualifier for out_data
sat_hi  output  1  current out_data clipped at the positive limit; valid with out_strobe
sat_lo  output  1  current out_data clipped at the negative limit; valid with out_strobe
sat_sticky  output  1  set on any clip; cleared only by clr_stats or reset
sat_count  output  CNT_W  number of clipped output samples, saturating at all-ones
clr_stats  input  1  synchronous clear of sat_sticky and sat_count

Behaviour:
- Reset (reset_n low, asynchronous): out_data, out_strobe, sat_hi, sat_lo, sat_sticky, sat_count all 0; pipeline valid bits 0. Reset asserted mid-stream drops in-flight samples immediately.
- Stage 1, on in_strobe && enable:
  - register in_data;
  - register eff_shift = min(shift_amt, MAX_SHIFT);
  - set valid1.
  - When in_strobe is low, valid1 = 0 and the data registers hold.
- Stage 2, when valid1:
  - wide = sign_extend(in_data) <<< eff_shift, computed at IN_LEN+MAX_SHIFT bits (exact, no loss);
  - clamp wide to [-2^(OUT_LEN-1), 2^(OUT_LEN-1)-1];
  - register out_data, sat_hi, sat_lo;
  - out_strobe = 1.
- Latency: exactly 2 clocks from in_strobe to out_strobe. Throughput: one sample per clock, so back-to-back strobes are supported.
- shift_amt changes take effect only for samples strobed in the same cycle. In-flight samples keep their own shift.
- Values exactly equal to a limit are not clipped: sat flags stay 0 and the counter does not increment.
- sat_hi and sat_lo are never both 1. Both are 0 in any cycle where out_strobe is 0.
- out_data holds its last value when out_strobe is 0.
- Statistics, per clipped output (sat_hi|sat_lo with out_strobe):
  - sat_sticky is set to 1;
  - sat_count increments, holding at 2^CNT_W-1.
- clr_stats has priority over a simultaneous clip event: that event is dropped, and sticky and count become 0.
- enable low: valid1 and out_strobe are forced to 0 next clock (in-flight samples discarded). Statistics and out_data are held. Inputs are ignored while enable is low.
- shift 0: output is the pure sign-extension of the input and can never clip, since OUT_LEN >= IN_LEN.

Decomposition:
- Shared package usrp_dsp_pkg holds:
  - signed full-scale constants as functions of width (max_s(w), min_s(w));
  - the clamp-shift helper (min of request and MAX_SHIFT).
- One natural sub-module: signed_saturate.
  - Combinational; parameters IN_W and OUT_W.
  - Inputs: a wide signed value.
  - Outputs: the clamped value plus hi/lo flags.
  - Reused by the stage-2 logic. The pipeline, enable handling and stats stay in the top.

Test Plan:
1. IN_LEN=16, OUT_LEN=24, MAX_SHIFT=12; in=-3, shift=4, one strobe -> 2 clocks later out_data=-48, out_strobe pulse of 1 cycle, sat_hi=sat_lo=0, sat_count=0.
2. in=0x7FFF, shift=12 -> out_data=8388607, sat_hi=1, sat_sticky=1, sat_count=1. Next sample in=-32768, shift=9 -> out_data=-8388608, sat_lo=1, sat_count=2. Then in=-32768, shift=8 -> out_data=-8388608 with sat_lo=0 and count unchanged.
3. in=1, shift_amt=31 -> clamped to 12, out_data=4096. Alternate shift 0/5 on back-to-back strobes with in=7 -> outputs 7, 224, 7, 224 on consecutive cycles.
4. 100 consecutive strobes of in=0x7FFF, shift=12 -> 100 out_strobes, sat_count=100. Preload the counter to 0xFFFE, then apply 3 clips -> holds at 0xFFFF.
5. clr_stats asserted in the same cycle as a clipped out_strobe -> sat_count=0 and sat_sticky=0 the next cycle. A subsequent clip -> count=1.
6. Drive strobes every cycle, then drop enable for 1 cycle -> no out_strobe for the two samples in flight, out_data held. Assert reset_n low between clock edges -> all outputs 0 before the next edge.
